// File: rtl/seg_pkg.sv
// seg_pkg: constants and helpers shared by the 7-segment scan driver and the
// segment encoders that feed it.
//   SEG_DP_BIT : decimal-point bit position in a standard 8-bit pattern
//   SEG_BLANK  : all-segments-off pattern (active-high)
//   pin_pol()  : active-high to pin-polarity conversion for output registers
package seg_pkg;

    localparam int SEG_W_STD  = 8;
    localparam int SEG_DP_BIT = SEG_W_STD - 1;
    localparam logic [SEG_W_STD-1:0] SEG_BLANK = '0;

    // Widest pin bus the helper handles; callers cast in and out.
    localparam int PIN_MAX_W = 64;

    // Converts an active-high internal vector to pin polarity.
    function automatic logic [PIN_MAX_W-1:0] pin_pol(
        input logic [PIN_MAX_W-1:0] v,
        input bit                   active_low
    );
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: slot timer for the digit scanner.
//   clk, reset : clock, async active-high reset
//   slot_cnt   : position within the current digit slot, 0..SLOT_CYCLES-1
//   slot_wrap  : high on the last cycle of a slot (slot_cnt == SLOT_CYCLES-1)
module scan_tick_gen #(
    parameter int SLOT_CYCLES = 200000,
    parameter int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             slot_wrap
);

    assign slot_wrap = (slot_cnt == CNT_W'(SLOT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          slot_cnt <= '0;
        else if (slot_wrap) slot_cnt <= '0;
        else                slot_cnt <= slot_cnt + 1'b1;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment bank driver.
// Scans NUM_DIGITS digits round-robin, one SLOT_CYCLES slot each. Every slot
// opens with BLANK_CYCLES dark cycles (anti-ghosting), then drives the digit
// with the pattern captured at the slot start, gated by the per-digit enable
// and a PWM brightness comparator.
//   clk, reset  : clock, async active-high reset
//   seg_in      : active-high patterns, digit i at [i*SEG_W +: SEG_W]
//   dp_mask     : per-digit decimal-point force-on
//   digit_en    : per-digit enable (0 = dark whole slot)
//   brightness  : PWM duty code, all-ones = always on
//   digitSelect : one-hot digit drive, pin polarity, registered
//   out         : segment drive, pin polarity, registered
//   frame_start : pulse marking the start of digit 0's slot, registered
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_W          = 8,
    parameter int SLOT_CYCLES    = 200000,
    parameter int BLANK_CYCLES   = 64,
    parameter int BRIGHT_W       = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [BRIGHT_W-1:0]         brightness,
    output logic [NUM_DIGITS-1:0]       digitSelect,
    output logic [SEG_W-1:0]            out,
    output logic                        frame_start
);

    localparam int CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam bit SEG_AL = (SEG_ACTIVE_LOW != 0);
    localparam bit DIG_AL = (DIG_ACTIVE_LOW != 0);

    // ---------------------------------------------------------------- timing
    logic [CNT_W-1:0] slot_cnt;
    logic             slot_wrap;
    logic             slot_start;
    logic             in_blank;

    scan_tick_gen #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .slot_cnt  (slot_cnt),
        .slot_wrap (slot_wrap)
    );

    assign slot_start = (slot_cnt == '0);

    // With no blanking the comparison would be constant-false; tie it off.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (slot_cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // ---------------------------------------------------------- digit index
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (slot_wrap)
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    // ------------------------------------------------- per-digit patterns
    // Decimal point merged with the force mask before the snapshot.
    logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_arr;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
            assign seg_arr[g] = {seg_in[g*SEG_W + SEG_W - 1] | dp_mask[g],
                                 seg_in[g*SEG_W +: SEG_W-1]};
        end
    endgenerate

    // ------------------------------------------------------------- snapshot
    logic [SEG_W-1:0] snap_pat;
    logic             snap_en;
    logic [SEG_W-1:0] live_pat;
    logic             live_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_pat <= SEG_W'(SEG_BLANK);
            snap_en  <= 1'b0;
        end else if (slot_start) begin
            snap_pat <= seg_arr[idx];
            snap_en  <= digit_en[idx];
        end
    end

    // On the first cycle of a slot the snapshot register is still loading,
    // so use the value being captured; this is what lets a zero-blank slot
    // light from its first cycle.
    assign live_pat = slot_start ? seg_arr[idx]  : snap_pat;
    assign live_en  = slot_start ? digit_en[idx] : snap_en;

    // ------------------------------------------------------------------ PWM
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic                pwm_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    // All-ones is special-cased so full brightness has no dark cycle.
    assign pwm_on = (&brightness) | (pwm_cnt < brightness);

    // ---------------------------------------------------------------- drive
    logic                  lit;
    logic [NUM_DIGITS-1:0] dig_drive;
    logic [SEG_W-1:0]      seg_drive;

    assign lit       = !in_blank && live_en && pwm_on;
    assign dig_drive = lit ? (NUM_DIGITS'(1) << idx) : '0;
    assign seg_drive = lit ? live_pat : SEG_W'(SEG_BLANK);

    // Polarity applied only here; everything upstream is active-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digitSelect <= NUM_DIGITS'(pin_pol('0, DIG_AL));
            out         <= SEG_W'(pin_pol('0, SEG_AL));
            frame_start <= 1'b0;
        end else begin
            digitSelect <= NUM_DIGITS'(pin_pol(PIN_MAX_W'(dig_drive), DIG_AL));
            out         <= SEG_W'(pin_pol(PIN_MAX_W'(seg_drive), SEG_AL));
            frame_start <= slot_start && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    logic clk = 1'b0;
    logic reset;

    // 4-digit instance: SLOT_CYCLES=8, BLANK_CYCLES=2
    logic [31:0] seg_in4;
    logic [3:0]  dp4, en4, br4;
    logic [3:0]  dig4;
    logic [7:0]  out4;
    logic        fs4;

    // 6-digit instance: SLOT_CYCLES=4, BLANK_CYCLES=0
    logic [47:0] seg_in6;
    logic [5:0]  dp6, en6;
    logic [3:0]  br6;
    logic [5:0]  dig6;
    logic [7:0]  out6;
    logic        fs6;

    seg_scan_mux #(
        .NUM_DIGITS(4), .SEG_W(8), .SLOT_CYCLES(8), .BLANK_CYCLES(2),
        .BRIGHT_W(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut4 (
        .clk(clk), .reset(reset), .seg_in(seg_in4), .dp_mask(dp4),
        .digit_en(en4), .brightness(br4), .digitSelect(dig4), .out(out4),
        .frame_start(fs4)
    );

    seg_scan_mux #(
        .NUM_DIGITS(6), .SEG_W(8), .SLOT_CYCLES(4), .BLANK_CYCLES(0),
        .BRIGHT_W(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut6 (
        .clk(clk), .reset(reset), .seg_in(seg_in6), .dp_mask(dp6),
        .digit_en(en6), .brightness(br6), .digitSelect(dig6), .out(out6),
        .frame_start(fs6)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int p;                      // cycle index since reset release shown on pins

    logic [7:0] exp_pat [4];    // expected pin-level pattern per digit (dut4)
    logic [3:0] exp_en;
    logic [3:0] exp_br;
    logic [7:0] pin6 [6];       // expected pin-level pattern per digit (dut6)

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, expv);
        end
    endtask

    task automatic check_cycle();
        int s, d, d6;
        logic lit;
        logic [3:0] ed;
        logic [7:0] eo;
        logic [5:0] ed6;
        logic [7:0] eo6;
        s   = p % 8;
        d   = (p / 8) % 4;
        lit = (s >= 2) && exp_en[d] && ((exp_br == 4'hF) || ((p % 16) < int'(exp_br)));
        ed  = lit ? ~(4'b0001 << d) : 4'hF;
        eo  = lit ? exp_pat[d] : 8'hFF;
        chk("dig4", 64'(dig4), 64'(ed));
        chk("out4", 64'(out4), 64'(eo));
        chk("fs4",  64'(fs4),  64'(p % 32 == 0));
        d6  = (p / 4) % 6;
        ed6 = ~(6'b000001 << d6);
        eo6 = pin6[d6];
        chk("dig6", 64'(dig6), 64'(ed6));
        chk("out6", 64'(out6), 64'(eo6));
        chk("fs6",  64'(fs6),  64'(p % 24 == 0));
    endtask

    task automatic run_to(input int pend);
        while (p < pend) begin
            @(posedge clk);
            #1;
            p++;
            check_cycle();
        end
    endtask

    initial begin
        reset   = 1'b1;
        seg_in4 = {8'h04, 8'h03, 8'h02, 8'h01};
        dp4 = 4'b0000; en4 = 4'b1111; br4 = 4'hF;
        seg_in6 = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        dp6 = 6'b0; en6 = 6'b111111; br6 = 4'hF;
        exp_pat = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
        exp_en  = 4'hF;
        exp_br  = 4'hF;
        pin6    = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99};
        p = -1;

        // Reset state
        #1;
        chk("rst_dig4", 64'(dig4), 64'(4'hF));
        chk("rst_out4", 64'(out4), 64'(8'hFF));
        chk("rst_fs4",  64'(fs4),  64'(1'b0));
        chk("rst_dig6", 64'(dig6), 64'(6'h3F));
        chk("rst_out6", 64'(out6), 64'(8'hFF));

        @(posedge clk); #1;
        reset = 1'b0;

        // Frame 1: plain scan order
        run_to(31);

        // Frame 2: digit 2 disabled, DP forced on digit 0
        en4 = 4'b1011; dp4 = 4'b0001;
        exp_en = 4'b1011; exp_pat[0] = 8'h7E;
        run_to(63);

        // Frame 3: brightness 0
        en4 = 4'hF; dp4 = 4'b0000; br4 = 4'h0;
        exp_en = 4'hF; exp_pat[0] = 8'hFE; exp_br = 4'h0;
        run_to(95);

        // Frame 4: brightness 8
        br4 = 4'h8; exp_br = 4'h8;
        run_to(127);

        // Frame 5: full brightness, digit 0 pattern changed mid-slot
        br4 = 4'hF; exp_br = 4'hF;
        run_to(130);
        seg_in4[7:0] = 8'h7F;
        run_to(159);

        // Frame 6 and into frame 7: new pattern now visible
        exp_pat[0] = 8'h80;
        run_to(194);

        // Asynchronous reset while digit 0 is lit
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_dig4", 64'(dig4), 64'(4'hF));
        chk("mid_rst_out4", 64'(out4), 64'(8'hFF));
        chk("mid_rst_fs4",  64'(fs4),  64'(1'b0));
        chk("mid_rst_dig6", 64'(dig6), 64'(6'h3F));
        chk("mid_rst_out6", 64'(out6), 64'(8'hFF));
        @(posedge clk); #1;
        reset = 1'b0;
        p = -1;
        run_to(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
